// File: rtl/mc_exec_sequencer.sv
// Multi-cycle execution sequencer: stalls the core, hands one request to a
// selected unit, waits with a timeout, then issues a single write-back.
module mc_exec_sequencer #(
  parameter int N_UNITS = 2,
  parameter int UNIT_W  = 1,
  parameter int MODE_W  = 21,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  input  logic [UNIT_W-1:0]     issue_unit,
  input  logic [MODE_W-1:0]     issue_mode,
  input  logic [4:0]            issue_rd,
  output logic [N_UNITS-1:0]    unit_req_valid,
  input  logic [N_UNITS-1:0]    unit_req_ready,
  output logic [MODE_W-1:0]     unit_mode,
  input  logic [N_UNITS-1:0]    unit_rsp_valid,
  input  logic [32*N_UNITS-1:0] unit_rsp_data,
  output logic                  hold,
  output logic                  ctrls_select,
  output logic                  regWrite,
  output logic [4:0]            wa,
  output logic [31:0]           wd,
  output logic                  busy,
  output logic                  err_timeout,
  output logic                  err_unit
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  localparam logic [UNIT_W:0] NU = (UNIT_W+1)'(N_UNITS);
  localparam logic [CNT_W-1:0] TC = CNT_W'(TIMEOUT - 1);

  logic [1:0]         r_state;
  logic [UNIT_W-1:0]  r_unit;
  logic [MODE_W-1:0]  r_mode;
  logic [4:0]         r_rd;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_wd;
  logic               r_err_to;
  logic               r_err_unit;

  logic               w_idle;
  logic               w_req;
  logic               w_wait;
  logic               w_wb;
  logic               w_legal;
  logic               w_rdy;
  logic               w_rsp;
  logic [31:0]        w_data;
  logic [N_UNITS-1:0] w_sel;

  assign w_idle  = (r_state == S_IDLE);
  assign w_req   = (r_state == S_REQ);
  assign w_wait  = (r_state == S_WAIT);
  assign w_wb    = (r_state == S_WB);
  assign w_legal = ({1'b0, issue_unit} < NU);

  // Only the latched unit's handshake lines are ever observed.
  always_comb begin
    w_rdy  = 1'b0;
    w_rsp  = 1'b0;
    w_data = '0;
    w_sel  = '0;
    for (int k = 0; k < N_UNITS; k++) begin
      if (r_unit == UNIT_W'(k)) begin
        w_sel[k] = 1'b1;
        w_rdy    = unit_req_ready[k];
        w_rsp    = unit_rsp_valid[k];
        w_data   = unit_rsp_data[32*k +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_unit     <= '0;
      r_mode     <= '0;
      r_rd       <= '0;
      r_cnt      <= '0;
      r_wd       <= '0;
      r_err_to   <= 1'b0;
      r_err_unit <= 1'b0;
    end else begin
      r_err_to   <= 1'b0;
      r_err_unit <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (issue_valid && w_legal) begin
            r_unit  <= issue_unit;
            r_mode  <= issue_mode;
            r_rd    <= issue_rd;
            r_state <= S_REQ;
          end else if (issue_valid) begin
            r_err_unit <= 1'b1;
          end
        end
        S_REQ: begin
          if (w_rdy) begin
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A response in the terminal-count cycle beats the abort.
          if (w_rsp) begin
            r_wd    <= w_data;
            r_state <= S_WB;
          end else if (r_cnt == TC) begin
            r_err_to <= 1'b1;
            r_state  <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign hold           = (w_idle & rst_n & issue_valid & w_legal) | w_req | w_wait;
  assign ctrls_select   = w_req | w_wait | w_wb;
  assign busy           = ~w_idle;
  assign unit_req_valid = w_req ? w_sel : '0;
  assign unit_mode      = w_idle ? '0 : r_mode;
  assign regWrite       = w_wb & (|r_rd);
  assign wa             = w_wb ? r_rd : 5'd0;
  assign wd             = w_wb ? r_wd : 32'd0;
  assign err_timeout    = r_err_to;
  assign err_unit       = r_err_unit;

endmodule

// File: tb/tb_mc_exec_sequencer.sv
// Directed bench for mc_exec_sequencer: handshake, latency, back-pressure,
// timeout, illegal unit, rd=0 and mid-flight reset.
module tb_mc_exec_sequencer;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic [1:0]  issue_unit;
  logic [20:0] issue_mode;
  logic [4:0]  issue_rd;
  logic [1:0]  unit_req_valid;
  logic [1:0]  unit_req_ready;
  logic [20:0] unit_mode;
  logic [1:0]  unit_rsp_valid;
  logic [63:0] unit_rsp_data;
  logic        hold;
  logic        ctrls_select;
  logic        regWrite;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        busy;
  logic        err_timeout;
  logic        err_unit;

  int tests = 0;
  int fails = 0;

  mc_exec_sequencer #(
    .N_UNITS(2), .UNIT_W(2), .MODE_W(21), .TIMEOUT(64), .CNT_W(7)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_unit(issue_unit),
    .issue_mode(issue_mode), .issue_rd(issue_rd),
    .unit_req_valid(unit_req_valid), .unit_req_ready(unit_req_ready),
    .unit_mode(unit_mode), .unit_rsp_valid(unit_rsp_valid),
    .unit_rsp_data(unit_rsp_data), .hold(hold),
    .ctrls_select(ctrls_select), .regWrite(regWrite),
    .wa(wa), .wd(wd), .busy(busy),
    .err_timeout(err_timeout), .err_unit(err_unit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] u, input logic [20:0] m,
                       input logic [4:0] rd);
    next_cycle();
    issue_valid = 1'b1;
    issue_unit  = u;
    issue_mode  = m;
    issue_rd    = rd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    issue_valid = 1'b1;
    issue_unit = 2'd1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    tests++;
    if ({unit_req_valid, unit_mode, hold, ctrls_select, regWrite, wa, wd,
         busy, err_timeout, err_unit} !== '0) begin
      fails++;
      $display("FAIL reset_outputs hold=%b busy=%b req=%b wd=%h want all 0",
               hold, busy, unit_req_valid, wd);
    end
    next_cycle();
    rst_n = 1'b1;
    issue_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || hold !== 1'b0) begin
      fails++;
      $display("FAIL reset_release busy=%b hold=%b want 0 0", busy, hold);
    end
  endtask

  task automatic test_basic();
    issue(2'd1, 21'h5, 5'd7);
    @(negedge clk);
    tests++;
    if (hold !== 1'b1 || busy !== 1'b0 || ctrls_select !== 1'b0) begin
      fails++;
      $display("FAIL basic_t hold=%b busy=%b ctrls=%b want 1 0 0",
               hold, busy, ctrls_select);
    end
    next_cycle();
    issue_valid = 1'b0;
    unit_req_ready = 2'b10;
    @(negedge clk);
    tests++;
    if (unit_req_valid !== 2'b10 || hold !== 1'b1 || unit_mode !== 21'h5 ||
        ctrls_select !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL basic_req req=%b hold=%b mode=%h want 10 1 5",
               unit_req_valid, hold, unit_mode);
    end
    next_cycle();
    unit_req_ready = 2'b00;
    unit_rsp_valid = 2'b10;
    unit_rsp_data = {32'hDEADBEEF, 32'h11111111};
    @(negedge clk);
    tests++;
    if (hold !== 1'b1 || unit_req_valid !== 2'b00) begin
      fails++;
      $display("FAIL basic_wait hold=%b req=%b want 1 00", hold, unit_req_valid);
    end
    next_cycle();
    unit_rsp_valid = 2'b00;
    @(negedge clk);
    tests++;
    if (regWrite !== 1'b1 || wa !== 5'd7 || wd !== 32'hDEADBEEF ||
        hold !== 1'b0 || ctrls_select !== 1'b1) begin
      fails++;
      $display("FAIL basic_wb we=%b wa=%0d wd=%h hold=%b want 1 7 deadbeef 0",
               regWrite, wa, wd, hold);
    end
    next_cycle();
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || regWrite !== 1'b0) begin
      fails++;
      $display("FAIL basic_idle busy=%b we=%b want 0 0", busy, regWrite);
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    int nwr = 0;
    int nto = 0;
    issue(2'd0, 21'h1ABCD, 5'd3);
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      issue_valid = 1'b0;
      unit_req_ready = (i == 5) ? 2'b01 : 2'b10;
      unit_rsp_valid = 2'b01;
      @(negedge clk);
      if (unit_req_valid !== 2'b01 || unit_mode !== 21'h1ABCD) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL bp_req_stable bad_cycles=%0d want 0", bad);
    end
    bad = 0;
    for (int i = 0; i < 11; i++) begin
      next_cycle();
      unit_req_ready = 2'b00;
      unit_rsp_valid = (i == 10) ? 2'b01 : 2'b10;
      unit_rsp_data = {32'h0BAD0BAD, 32'h12345678};
      @(negedge clk);
      if (hold !== 1'b1 || busy !== 1'b1 || unit_req_valid !== 2'b00) bad++;
      nwr += int'(regWrite);
      nto += int'(err_timeout);
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL bp_wait bad_cycles=%0d want 0", bad);
    end
    next_cycle();
    unit_rsp_valid = 2'b00;
    @(negedge clk);
    tests++;
    if (regWrite !== 1'b1 || wa !== 5'd3 || wd !== 32'h12345678) begin
      fails++;
      $display("FAIL bp_wb we=%b wa=%0d wd=%h want 1 3 12345678",
               regWrite, wa, wd);
    end
    nwr += int'(regWrite);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      @(negedge clk);
      nwr += int'(regWrite);
      nto += int'(err_timeout);
    end
    tests++;
    if (nwr != 1 || nto != 0) begin
      fails++;
      $display("FAIL bp_counts writes=%0d timeouts=%0d want 1 0", nwr, nto);
    end
  endtask

  task automatic test_timeout();
    int bad = 0;
    int nwr = 0;
    int nto = 0;
    issue(2'd1, 21'h7, 5'd5);
    next_cycle();
    issue_valid = 1'b0;
    unit_req_ready = 2'b10;
    for (int i = 1; i <= 64; i++) begin
      next_cycle();
      unit_req_ready = 2'b00;
      @(negedge clk);
      if (hold !== 1'b1 || busy !== 1'b1) bad++;
      nwr += int'(regWrite);
      nto += int'(err_timeout);
    end
    tests++;
    if (bad != 0 || nto != 0) begin
      fails++;
      $display("FAIL to_wait bad=%0d early_to=%0d want 0 0", bad, nto);
    end
    next_cycle();
    @(negedge clk);
    tests++;
    if (err_timeout !== 1'b1 || hold !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL to_abort to=%b hold=%b busy=%b want 1 0 0",
               err_timeout, hold, busy);
    end
    nwr += int'(regWrite);
    next_cycle();
    @(negedge clk);
    tests++;
    if (err_timeout !== 1'b0 || nwr != 0) begin
      fails++;
      $display("FAIL to_pulse to=%b writes=%0d want 0 0", err_timeout, nwr);
    end
  endtask

  task automatic test_terminal();
    issue(2'd1, 21'h8, 5'd12);
    next_cycle();
    issue_valid = 1'b0;
    unit_req_ready = 2'b10;
    for (int i = 1; i <= 64; i++) begin
      next_cycle();
      unit_req_ready = 2'b00;
      if (i == 64) begin
        unit_rsp_valid = 2'b10;
        unit_rsp_data = {32'hCAFEF00D, 32'h0};
      end
    end
    next_cycle();
    unit_rsp_valid = 2'b00;
    @(negedge clk);
    tests++;
    if (regWrite !== 1'b1 || wa !== 5'd12 || wd !== 32'hCAFEF00D ||
        err_timeout !== 1'b0) begin
      fails++;
      $display("FAIL tc_wb we=%b wa=%0d wd=%h to=%b want 1 12 cafef00d 0",
               regWrite, wa, wd, err_timeout);
    end
    next_cycle();
    @(negedge clk);
    tests++;
    if (err_timeout !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL tc_after to=%b busy=%b want 0 0", err_timeout, busy);
    end
  endtask

  task automatic test_bad_unit();
    issue(2'd3, 21'h1, 5'd4);
    @(negedge clk);
    tests++;
    if (hold !== 1'b0 || busy !== 1'b0 || err_unit !== 1'b0) begin
      fails++;
      $display("FAIL bad_issue hold=%b busy=%b eu=%b want 0 0 0",
               hold, busy, err_unit);
    end
    next_cycle();
    issue_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (err_unit !== 1'b1 || busy !== 1'b0 || hold !== 1'b0 ||
        unit_req_valid !== 2'b00) begin
      fails++;
      $display("FAIL bad_pulse eu=%b busy=%b hold=%b req=%b want 1 0 0 00",
               err_unit, busy, hold, unit_req_valid);
    end
    next_cycle();
    @(negedge clk);
    tests++;
    if (err_unit !== 1'b0) begin
      fails++;
      $display("FAIL bad_clear eu=%b want 0", err_unit);
    end
  endtask

  task automatic test_rd0();
    issue(2'd0, 21'h9, 5'd0);
    next_cycle();
    issue_valid = 1'b0;
    unit_req_ready = 2'b01;
    next_cycle();
    unit_req_ready = 2'b00;
    unit_rsp_valid = 2'b01;
    unit_rsp_data = {32'hFFFFFFFF, 32'hA5A5A5A5};
    next_cycle();
    unit_rsp_valid = 2'b00;
    @(negedge clk);
    tests++;
    if (regWrite !== 1'b0 || busy !== 1'b1 || ctrls_select !== 1'b1 ||
        wd !== 32'hA5A5A5A5) begin
      fails++;
      $display("FAIL rd0_wb we=%b busy=%b ctrls=%b wd=%h want 0 1 1 a5a5a5a5",
               regWrite, busy, ctrls_select, wd);
    end
    next_cycle();
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL rd0_idle busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    issue(2'd1, 21'h3, 5'd9);
    next_cycle();
    issue_valid = 1'b0;
    unit_req_ready = 2'b10;
    next_cycle();
    unit_req_ready = 2'b00;
    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    unit_rsp_valid = 2'b10;
    unit_rsp_data = {32'h5555AAAA, 32'h0};
    @(negedge clk);
    tests++;
    if ({unit_req_valid, unit_mode, hold, ctrls_select, regWrite, wa, wd,
         busy, err_timeout, err_unit} !== '0) begin
      fails++;
      $display("FAIL rst_mid busy=%b hold=%b ctrls=%b we=%b want all 0",
               busy, hold, ctrls_select, regWrite);
    end
    next_cycle();
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || regWrite !== 1'b0) begin
      fails++;
      $display("FAIL rst_late_rsp busy=%b we=%b want 0 0", busy, regWrite);
    end
    unit_rsp_valid = 2'b00;
  endtask

  initial begin
    rst_n = 1'b0;
    issue_valid = 1'b0;
    issue_unit = '0;
    issue_mode = '0;
    issue_rd = '0;
    unit_req_ready = '0;
    unit_rsp_valid = '0;
    unit_rsp_data = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_timeout();
    test_terminal();
    test_bad_unit();
    test_rd0();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
